// File: rtl/bch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bch_pkg
//  Description : Shared types and default constants for the BCH encoder.
//                Holds the encoder FSM state type and its encodings, the
//                default (15,5) code parameters, and a helper that checks
//                whether a parameter set describes a usable generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package bch_pkg;

    // Default (15,5) triple-error-correcting BCH code.
    localparam int          BCH_N        = 15;
    localparam int          BCH_K        = 5;
    localparam logic [10:0] BCH_GEN_POLY = 11'h537;

    // Encoder FSM state type and encodings.
    typedef logic [1:0] bch_state_t;

    localparam bch_state_t ST_IDLE  = 2'd0;
    localparam bch_state_t ST_SHIFT = 2'd1;
    localparam bch_state_t ST_OUT   = 2'd2;

    // A generator of degree n-k must have both its leading and constant
    // coefficients set, and the code must carry at least one parity bit.
    function automatic bit bch_params_ok(input int n, input int k,
                                         input logic [63:0] poly);
        if (n <= k || k < 1) begin
            return 1'b0;
        end
        return poly[n-k] && poly[0];
    endfunction

endpackage : bch_pkg
`default_nettype wire

// File: rtl/bch_lfsr_div.sv
`default_nettype none
// ============================================================================
//  Module      : bch_lfsr_div
//  Description : Serial polynomial divider computing the remainder of
//                msg(x) * x^W modulo GEN_POLY(x), one message bit per
//                enabled clock, highest-order coefficient first.
//
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-high reset
//                clear     - zero the remainder (start of a new message)
//                shift_en  - consume bit_in this clock
//                bit_in    - next message bit, MSB first
//                remainder - current remainder, W bits (parity on completion)
//  Revision    : 1.0 - initial release
// ============================================================================
module bch_lfsr_div
    import bch_pkg::*;
#(
    parameter int           W        = BCH_N - BCH_K,
    parameter logic [W:0]   GEN_POLY = (W+1)'(BCH_GEN_POLY)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [W-1:0] remainder
);

    // The x^W term is implicit in the shift-out of the top stage, so only
    // the lower W coefficients act as feedback taps.
    localparam logic [W-1:0] c_TAPS = GEN_POLY[W-1:0];

    logic [W-1:0] r_rem;
    logic         w_fb;
    logic [W-1:0] w_next;

    // Feedback combines the incoming bit with the coefficient leaving the
    // register; shifting by one with '<<' keeps this valid for W == 1.
    assign w_fb   = bit_in ^ r_rem[W-1];
    assign w_next = (r_rem << 1) ^ (w_fb ? c_TAPS : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
        end else if (clear) begin
            r_rem <= '0;
        end else if (shift_en) begin
            r_rem <= w_next;
        end
    end

    assign remainder = r_rem;

endmodule : bch_lfsr_div
`default_nettype wire

// File: rtl/bch_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module      : bch_encoder_param
//  Description : Parametrised systematic BCH encoder with error injection.
//                An accepted start latches the message and error mask, the
//                message is fed MSB first through a serial divider for K
//                clocks, and one clock later the codeword {msg, parity} and
//                its masked copy are registered with a one-cycle done pulse.
//                Throughput is one word per K+2 clocks.
//
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-high reset
//                start     - encode request, sampled only while idle
//                data_in   - K-bit message, latched on accepted start
//                err_mask  - N-bit error mask, latched on accepted start
//                codeword  - N-bit systematic codeword, registered
//                corrupted - codeword XOR latched mask, registered
//                done      - one-cycle pulse when outputs update
//                busy      - high while shifting or presenting output
//  Revision    : 1.0 - initial release
// ============================================================================
module bch_encoder_param
    import bch_pkg::*;
#(
    parameter int             N        = BCH_N,
    parameter int             K        = BCH_K,
    parameter logic [N-K:0]   GEN_POLY = (N-K+1)'(BCH_GEN_POLY)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [K-1:0] data_in,
    input  logic [N-1:0] err_mask,
    output logic [N-1:0] codeword,
    output logic [N-1:0] corrupted,
    output logic         done,
    output logic         busy
);

    localparam int                 c_PAR_W    = N - K;
    localparam int                 c_CNT_W    = $clog2(K + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(K - 1);

    // Reject parameter sets that cannot form a valid cyclic code.
    generate
        if (!bch_params_ok(N, K, 64'(GEN_POLY))) begin : g_bad_params
            $error("bch_encoder_param: need N > K >= 1 and GEN_POLY with leading and constant terms set");
        end
    endgenerate

    bch_state_t          r_state;
    logic [K-1:0]        r_msg;
    logic [K-1:0]        r_shreg;
    logic [N-1:0]        r_mask;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [N-1:0]        r_codeword;
    logic [N-1:0]        r_corrupted;
    logic                r_done;

    logic                w_accept;
    logic                w_shift;
    logic [c_PAR_W-1:0]  w_rem;
    logic [N-1:0]        w_cw_next;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_shift   = (r_state == ST_SHIFT);
    assign w_cw_next = {r_msg, w_rem};

    // The divider is cleared in the same edge that accepts a message, so the
    // first SHIFT edge already sees a zero remainder.
    bch_lfsr_div #(
        .W        (c_PAR_W),
        .GEN_POLY (GEN_POLY)
    ) u_lfsr_div (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_accept),
        .shift_en  (w_shift),
        .bit_in    (r_shreg[K-1]),
        .remainder (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_msg       <= '0;
            r_shreg     <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_codeword  <= '0;
            r_corrupted <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_msg   <= data_in;
                        r_shreg <= data_in;
                        r_mask  <= err_mask;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // r_shreg walks the message past its MSB tap; r_msg is
                    // kept intact for the systematic part of the codeword.
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    r_codeword  <= w_cw_next;
                    r_corrupted <= w_cw_next ^ r_mask;
                    r_done      <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign codeword  = r_codeword;
    assign corrupted = r_corrupted;
    assign done      = r_done;
    assign busy      = (r_state == ST_SHIFT) || (r_state == ST_OUT);

endmodule : bch_encoder_param
`default_nettype wire
